// File: rtl/seg_reader.sv
// Receive side of the multiplexed seven-segment bus: debounces each scan slot and
// decodes the active-low glyph back into a hex nibble per digit position.
module seg_reader #(
    parameter int DIGITS        = 6,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     err,
    output logic                  update,
    output logic [2:0]            upd_idx
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic { WAIT, CAPTURED } state_t;
    typedef enum logic [1:0] { GLYPH, BLANK, ILLEGAL } kind_t;

    typedef struct packed {
        logic [DIGITS-1:0] sel;
        logic [6:0]        seg;
    } sample_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] nib;
    } decode_t;

    function automatic decode_t decode(input logic [6:0] s);
        decode_t d;
        d.kind = GLYPH;
        d.nib  = 4'h0;
        case (s)
            7'b1000000: d.nib = 4'h0;
            7'b1111001: d.nib = 4'h1;
            7'b0100100: d.nib = 4'h2;
            7'b0110000: d.nib = 4'h3;
            7'b0011001: d.nib = 4'h4;
            7'b0010010: d.nib = 4'h5;
            7'b0000010: d.nib = 4'h6;
            7'b1111000: d.nib = 4'h7;
            7'b0000000: d.nib = 4'h8;
            7'b0010000: d.nib = 4'h9;
            7'b0001000: d.nib = 4'hA;
            7'b0000011: d.nib = 4'hB;
            7'b1000110: d.nib = 4'hC;
            7'b0100001: d.nib = 4'hD;
            7'b0000110: d.nib = 4'hE;
            7'b0001110: d.nib = 4'hF;
            7'b1111111: d.kind = BLANK;
            default:    d.kind = ILLEGAL;
        endcase
        return d;
    endfunction

    state_t             state;
    sample_t            held;
    sample_t            cur;
    logic [CNT_W-1:0]   cnt;
    logic               onehot;
    logic               match;
    logic [2:0]         sel_idx;
    decode_t            dec;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a path that skips it infers a latch.
    always_comb begin
        cur     = '{sel: dig_sel, seg: seg_in};
        onehot  = $onehot(dig_sel);
        match   = (cur == held);
        dec     = decode(seg_in);
        sel_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_sel[k]) sel_idx = 3'(k);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT;
            held        <= '0;
            cnt         <= '0;
            value       <= '0;
            digit_valid <= '0;
            err         <= '0;
            update      <= 1'b0;
            upd_idx     <= '0;
        end else begin
            update <= 1'b0;
            if (!match || !onehot) begin
                // A new or malformed sample restarts the stability window.
                held  <= cur;
                cnt   <= onehot ? CNT_W'(1) : '0;
                state <= WAIT;
            end else begin
                if (cnt != CNT_W'(STABLE_CYCLES)) cnt <= cnt + CNT_W'(1);
                if (state == WAIT && cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state   <= CAPTURED;
                    update  <= 1'b1;
                    upd_idx <= sel_idx;
                    for (int k = 0; k < DIGITS; k++) begin
                        if (dig_sel[k]) begin
                            case (dec.kind)
                                GLYPH: begin
                                    value[4*k +: 4] <= dec.nib;
                                    digit_valid[k]  <= 1'b1;
                                    err[k]          <= 1'b0;
                                end
                                BLANK: begin
                                    value[4*k +: 4] <= 4'h0;
                                    digit_valid[k]  <= 1'b0;
                                    err[k]          <= 1'b0;
                                end
                                default: begin
                                    // Illegal glyph keeps the last good nibble.
                                    digit_valid[k]  <= 1'b0;
                                    err[k]          <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: a run-length reference model queues expected
// captures; a negedge monitor pops and compares on every update pulse.
module tb_seg_reader;

    localparam int DIGITS = 6;
    localparam int STABLE = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [6:0]           seg_in;
    logic [DIGITS-1:0]    dig_sel;
    logic [4*DIGITS-1:0]  value;
    logic [DIGITS-1:0]    digit_valid;
    logic [DIGITS-1:0]    err;
    logic                 update;
    logic [2:0]           upd_idx;

    seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .value(value), .digit_valid(digit_valid), .err(err),
        .update(update), .upd_idx(upd_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int upd_seen = 0;
    int pushed   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive identical one-hot samples.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [2:0]          idx;
        logic [4*DIGITS-1:0] val;
        logic [DIGITS-1:0]   valid;
        logic [DIGITS-1:0]   errv;
    } exp_t;

    exp_t                q[$];
    int                  run;
    logic [DIGITS-1:0]   prev_sel;
    logic [6:0]          prev_seg;
    logic [3:0]          m_val [DIGITS];
    logic [DIGITS-1:0]   m_valid;
    logic [DIGITS-1:0]   m_err;

    function automatic logic [4*DIGITS-1:0] m_value();
        logic [4*DIGITS-1:0] v = '0;
        for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = m_val[k];
        return v;
    endfunction

    task automatic model_reset();
        run      = 0;
        prev_sel = '0;
        prev_seg = '0;
        m_valid  = '0;
        m_err    = '0;
        for (int k = 0; k < DIGITS; k++) m_val[k] = 4'h0;
    endtask

    task automatic model_step(input logic [DIGITS-1:0] sel, input logic [6:0] seg);
        bit   oh = ($countones(sel) == 1);
        int   k = 0;
        int   nib = -1;
        exp_t e;
        if (oh && sel == prev_sel && seg == prev_seg) run++;
        else run = oh ? 1 : 0;
        prev_sel = sel;
        prev_seg = seg;
        if (oh && run == STABLE) begin
            for (int i = 0; i < DIGITS; i++) if (sel[i]) k = i;
            for (int g = 0; g < 16; g++) if (glyph[g] == seg) nib = g;
            if (nib >= 0) begin
                m_val[k] = 4'(nib); m_valid[k] = 1'b1; m_err[k] = 1'b0;
            end else if (seg == 7'b1111111) begin
                m_val[k] = 4'h0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
            end else begin
                m_valid[k] = 1'b0; m_err[k] = 1'b1;
            end
            e.idx = 3'(k); e.val = m_value(); e.valid = m_valid; e.errv = m_err;
            q.push_back(e);
            pushed++;
        end
    endtask

    // Starts and ends just after a falling edge; holds the inputs for n rising edges.
    task automatic drive(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) begin
            @(posedge clk);
            model_step(sel, seg);
            @(negedge clk);
            #1;
        end
    endtask

    // Monitor: compares each update pulse against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (update === 1'b1) begin
                upd_seen++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update: got update=1 idx=%0d expected no capture at %0t", upd_idx, $time);
                end else begin
                    e = q.pop_front();
                    check("upd_idx", 32'(upd_idx), 32'(e.idx));
                    check("value", 32'(value), 32'(e.val));
                    check("digit_valid", 32'(digit_valid), 32'(e.valid));
                    check("err", 32'(err), 32'(e.errv));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*DIGITS-1:0] snap_val;
        logic [DIGITS-1:0]   snap_valid;
        logic [DIGITS-1:0]   snap_err;
        int                  snap_upd;
        logic [DIGITS-1:0]   sel;
        logic [6:0]          seg;
        int                  a, b, r;

        reset_n = 1'b0;
        dig_sel = '0;
        seg_in  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_update", 32'(update), 32'h0);
        check("reset_upd_idx", 32'(upd_idx), 32'h0);
        reset_n = 1'b1;

        // Basic capture of '2' on digit 0.
        drive(6'b000001, 7'b0100100, 3);
        check("t1_update", 32'(update), 32'h1);
        check("t1_idx", 32'(upd_idx), 32'h0);
        check("t1_nibble", 32'(value[3:0]), 32'h2);
        check("t1_valid", 32'(digit_valid), 32'h01);

        // Holding the same input produces no further pulses.
        drive(6'b000001, 7'b0100100, 10);
        check("t2_pulses", 32'(upd_seen), 32'h1);
        check("t2_nibble", 32'(value[3:0]), 32'h2);

        // Short-lived 'b' is discarded; following 'E' is captured.
        drive(6'b000100, 7'b0000011, 2);
        drive(6'b000100, 7'b0000110, 3);
        check("t3_nibble", 32'(value[11:8]), 32'hE);
        check("t3_idx", 32'(upd_idx), 32'h2);

        // Digit 5: '7', then illegal keeps the nibble, then blank clears it.
        drive(6'b100000, 7'b1111000, 3);
        check("t4_seven", 32'(value[23:20]), 32'h7);
        drive(6'b100000, 7'b1010101, 3);
        check("t4_err", 32'(err[5]), 32'h1);
        check("t4_valid", 32'(digit_valid[5]), 32'h0);
        check("t4_keep", 32'(value[23:20]), 32'h7);
        drive(6'b100000, 7'b1111111, 3);
        check("t4_blank_err", 32'(err[5]), 32'h0);
        check("t4_blank_val", 32'(value[23:20]), 32'h0);

        // Multi-hot select never captures.
        snap_val = value; snap_valid = digit_valid; snap_err = err; snap_upd = upd_seen;
        drive(6'b000011, 7'b1111001, 8);
        check("t5_no_update", 32'(upd_seen), 32'(snap_upd));
        check("t5_value_hold", 32'(value), 32'(snap_val));
        check("t5_valid_hold", 32'(digit_valid), 32'(snap_valid));
        check("t5_err_hold", 32'(err), 32'(snap_err));
        drive(6'b000010, 7'b1111001, 3);
        check("t5_one", 32'(value[7:4]), 32'h1);

        // Reset in the middle of a stability window.
        drive(6'b000001, 7'b0010010, 2);
        snap_upd = upd_seen;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_value", 32'(value), 32'h0);
        check("t6_valid", 32'(digit_valid), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("t6_update", 32'(update), 32'h0);
        check("t6_no_pulse", 32'(upd_seen), 32'(snap_upd));
        check("t6_value_low", 32'(value), 32'h0);
        reset_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, DIGITS - 1);
            if (r == 0) sel = '0;
            else if (r == 1) begin
                b = (a + 1 + $urandom_range(0, DIGITS - 2)) % DIGITS;
                sel = DIGITS'((1 << a) | (1 << b));
            end else sel = DIGITS'(1 << a);
            r = $urandom_range(0, 9);
            if (r < 7) seg = glyph[$urandom_range(0, 15)];
            else if (r == 7) seg = 7'b1111111;
            else seg = 7'($urandom);
            drive(sel, seg, $urandom_range(1, 5));
        end

        drive('0, 7'b1111111, 3);
        check("final_queue_empty", 32'(q.size()), 32'h0);
        check("final_pulse_count", 32'(upd_seen), 32'(pushed));
        check("final_value", 32'(value), 32'(m_value()));
        check("final_valid", 32'(digit_valid), 32'(m_valid));
        check("final_err", 32'(err), 32'(m_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Receive side of the seven-segment digit interface; decodes in the opposite direction to the hex-to-segment encoder.
- Samples a time-multiplexed, active-low segment bus (seg_in plus one-hot digit select) and rebuilds the hex nibble shown on each digit.
- Used by on-board self-check logic and benches to read back what the display drivers emit.
- Filters scan glitches with a stability counter and flags segment patterns that are not valid hex glyphs.

Parameters:
- DIGITS, 6, number of scanned digit positions (1..8).
- STABLE_CYCLES, 3, consecutive identical samples required before capture (>=2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  active-low segments, bit0=a … bit6=g (0 = lit).
- dig_sel  input  DIGITS  one-hot select of the digit currently driven.
- value  output  4*DIGITS  decoded nibble per digit; digit k at [4k+3:4k].
- digit_valid  output  DIGITS  digit k holds a valid captured glyph.
- err  output  DIGITS  last capture on digit k was an illegal pattern (sticky until the next valid or blank capture on k).
- update  output  1  one-cycle pulse after any capture.
- upd_idx  output  3  index of the digit captured; valid when update=1.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release): value=0, digit_valid=0, err=0, update=0, upd_idx=0, cnt=0, FSM=WAIT, held sample cleared.
- Held sample: register {dig_sel, seg_in}. On every edge, if the input differs from the held sample or dig_sel is not one-hot: reload the held sample, cnt=1, FSM=WAIT (cnt=0 if not one-hot).
- FSM WAIT: input matches the held sample and dig_sel is one-hot -> cnt increments. On the edge where the match is seen with cnt==STABLE_CYCLES-1, capture occurs and FSM goes to CAPTURED.
- FSM CAPTURED: no further capture while the input stays unchanged. cnt saturates. Any change returns FSM to WAIT.
- Capture latency: a pattern present at STABLE_CYCLES consecutive edges is captured on the last of those edges. value, digit_valid and err change on that edge; update=1 for the following cycle only.
- Decode table (seg_in[6:0] -> nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 1000110=C, 0100001=d, 0000110=E, 0001110=F
- Blank pattern 1111111: value[k]=0, digit_valid[k]=0, err[k]=0.
- Any other pattern: value[k] unchanged, digit_valid[k]=0, err[k]=1.
- Legal glyph: value[k]=nibble, digit_valid[k]=1, err[k]=0.
- Only the selected digit k changes on a capture; other digits hold their state.
- upd_idx = binary index of the set dig_sel bit.
- dig_sel all-zero or multi-hot: never captures; all outputs hold.
- Reset asserted mid-count: no capture occurs; all state returns to reset values immediately.

Test Plan:
- Reset, then seg_in=0100100, dig_sel=000001 held 3 edges -> after edge 3: value[3:0]=2, digit_valid=000001, update one cycle, upd_idx=0.
- Same input held 10 more edges -> exactly one update pulse in total; value unchanged.
- seg_in=0000011 on dig_sel=000100 held 2 edges, then changed to 0000110 for 3 edges -> no capture of b; value[11:8]=E, upd_idx=2.
- Illegal seg_in=1010101 on digit 5 for 3 edges -> err[5]=1, digit_valid[5]=0, value[23:20] unchanged. Then 1111111 for 3 edges -> err[5]=0, value[23:20]=0.
- dig_sel=000011 with seg_in=1111001 held 8 edges -> no update, outputs unchanged. Then dig_sel=000010 -> capture after 3 edges, value[7:4]=1.
- Deassert reset_n after 2 matching edges -> update never pulses; all outputs 0 while reset is low.
